o_serializer: RTL and testbench

Output-direction serializer for the I/O primitive library: accepts parallel words over a valid/ready handshake and drives them one bit per clock toward an output pad buffer. It provides a data pin `Q` plus a tristate enable `OE`, sized to feed a tristate output buffer directly. A one-word holding register lets consecutive words stream with no idle bit between them. This is the transmit-side counterpart of the single-ended input buffer path.

---
 rtl/o_serializer.sv | 154 +++++++++++++++
 tb/tb_o_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/o_serializer.sv
// o_serializer: output-direction serializer for the I/O primitive library.
// Accepts parallel words over a valid/ready handshake and drives them one bit
// per enabled clock on Q, with OE framing the data for a tristate pad buffer.
// A one-word holding register lets consecutive words stream with no idle bit.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   EN       in   block enable; low freezes all state
//   D        in   parallel word (WIDTH bits)
//   D_VALID  in   D holds a valid word
//   D_READY  out  combinational: a word can be accepted this cycle
//   Q        out  registered serial data
//   OE       out  registered output enable, high while Q carries data
//   BUSY     out  registered: word in shifter or holding register
module o_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter string       BIT_ORDER  = "LSB_FIRST",
    parameter string       IDLE_VALUE = "HIGH"
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             Q,
    output logic             OE,
    output logic             BUSY
);

    // Parameter legality, rejected at elaboration
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "%m: WIDTH=%0d outside legal range 2..16", WIDTH);
    end
    if (BIT_ORDER != "LSB_FIRST" && BIT_ORDER != "MSB_FIRST") begin : g_bad_order
        $fatal(1, "%m: BIT_ORDER must be \"LSB_FIRST\" or \"MSB_FIRST\"");
    end
    if (IDLE_VALUE != "HIGH" && IDLE_VALUE != "LOW") begin : g_bad_idle
        $fatal(1, "%m: IDLE_VALUE must be \"HIGH\" or \"LOW\"");
    end

    localparam int unsigned CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit   MSB_ORDER     = (BIT_ORDER == "MSB_FIRST");
    localparam logic IDLE_Q        = (IDLE_VALUE == "HIGH") ? 1'b1 : 1'b0;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state,     state_nxt;
    logic [WIDTH-1:0] sh,        sh_nxt;
    logic [CW-1:0]    cnt,       cnt_nxt;
    logic [WIDTH-1:0] hold,      hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic             q_r,       q_nxt;
    logic             oe_r,      oe_nxt;
    logic             busy_r,    busy_nxt;

    logic             accept;
    logic             do_load;
    logic [WIDTH-1:0] load_word;

    // Bit that goes on Q first for a freshly loaded word
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_ORDER ? w[WIDTH-1] : w[0];
    endfunction

    // Shift the next bit into the position first_bit() reads
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_ORDER ? (w << 1) : (w >> 1);
    endfunction

    assign D_READY = !RST && EN && !hold_full;
    assign accept  = D_VALID && D_READY;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        q_nxt         = q_r;
        oe_nxt        = oe_r;
        do_load       = 1'b0;
        load_word     = D;

        if (EN) begin
            if (state == S_IDLE || cnt == LAST) begin
                // Word boundary: held word first, then a bypass load, else go idle
                if (hold_full) begin
                    do_load       = 1'b1;
                    load_word     = hold;
                    hold_full_nxt = 1'b0;
                end else if (accept) begin
                    do_load = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                    q_nxt     = IDLE_Q;
                    oe_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end
            end else begin
                // Mid-word: drive the next bit, park any new word
                q_nxt   = first_bit(sh);
                sh_nxt  = advance(sh);
                cnt_nxt = cnt + CW'(1);
                if (accept) begin
                    hold_nxt      = D;
                    hold_full_nxt = 1'b1;
                end
            end

            if (do_load) begin
                state_nxt = S_SHIFT;
                q_nxt     = first_bit(load_word);
                sh_nxt    = advance(load_word);
                cnt_nxt   = '0;
                oe_nxt    = 1'b1;
            end
        end

        busy_nxt = (state_nxt == S_SHIFT) || hold_full_nxt;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            sh        <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            q_r       <= IDLE_Q;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            q_r       <= q_nxt;
            oe_r      <= oe_nxt;
            busy_r    <= busy_nxt;
        end
    end

    assign Q    = q_r;
    assign OE   = oe_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_o_serializer.sv
// tb_o_serializer: checks two o_serializer instances (8-bit LSB-first idle-high,
// 4-bit MSB-first idle-low). Expected serial bits are queued when a word is
// accepted and popped as each enabled edge drives a new bit.
`timescale 1ns/1ps
module tb_o_serializer;

    localparam int unsigned WA = 8;
    localparam int unsigned WB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en;
    logic [WA-1:0] a_d;
    logic          a_valid, a_ready, a_q, a_oe, a_busy;
    logic [WB-1:0] b_d;
    logic          b_valid, b_ready, b_q, b_oe, b_busy;

    o_serializer #(.WIDTH(WA), .BIT_ORDER("LSB_FIRST"), .IDLE_VALUE("HIGH")) dut_a (
        .CLK(clk), .RST(rst), .EN(en), .D(a_d), .D_VALID(a_valid),
        .D_READY(a_ready), .Q(a_q), .OE(a_oe), .BUSY(a_busy)
    );

    o_serializer #(.WIDTH(WB), .BIT_ORDER("MSB_FIRST"), .IDLE_VALUE("LOW")) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .D(b_d), .D_VALID(b_valid),
        .D_READY(b_ready), .Q(b_q), .OE(b_oe), .BUSY(b_busy)
    );

    // exp lists the serial bits in drive order, first bit on the left
    typedef struct { logic [WA-1:0] d; logic [WA-1:0] exp; bit b2b; } vec_a_t;
    typedef struct { logic [WB-1:0] d; logic [WB-1:0] exp; } vec_b_t;

    vec_a_t va [8];
    vec_b_t vb [3];

    int   n_vec = 0;
    int   n_err = 0;
    logic qa [$];
    logic qb [$];
    bit   mon_on   = 1'b0;
    bit   prev_rst = 1'b1;
    bit   prev_en  = 1'b0;
    logic ma_q, ma_oe, mb_q, mb_oe;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Model and compare: outputs after the last edge, then note what the next edge sees
    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_rst) begin
                qa.delete();
                qb.delete();
                ma_q = 1'b1; ma_oe = 1'b0;
                mb_q = 1'b0; mb_oe = 1'b0;
            end else if (prev_en) begin
                if (qa.size() > 0) begin ma_q = qa.pop_front(); ma_oe = 1'b1; end
                else begin ma_q = 1'b1; ma_oe = 1'b0; end
                if (qb.size() > 0) begin mb_q = qb.pop_front(); mb_oe = 1'b1; end
                else begin mb_q = 1'b0; mb_oe = 1'b0; end
            end
            check("a_q",     a_q,     ma_q);
            check("a_oe",    a_oe,    ma_oe);
            check("a_busy",  a_busy,  (ma_oe || qa.size() > 0) ? 1'b1 : 1'b0);
            check("a_ready", a_ready, (!rst && en && qa.size() < int'(WA)) ? 1'b1 : 1'b0);
            check("b_q",     b_q,     mb_q);
            check("b_oe",    b_oe,    mb_oe);
            check("b_busy",  b_busy,  (mb_oe || qb.size() > 0) ? 1'b1 : 1'b0);
            check("b_ready", b_ready, (!rst && en && qb.size() < int'(WB)) ? 1'b1 : 1'b0);
        end
        prev_rst = rst;
        prev_en  = en && !rst;
    end

    // Present a word and wait for the handshake; returns just after the accepting edge
    task automatic send_a(input logic [WA-1:0] d, input logic [WA-1:0] exp);
        bit done = 1'b0;
        a_d = d;
        a_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #2;
            if (a_ready === 1'b1 && en && !rst) begin
                for (int k = int'(WA) - 1; k >= 0; k--) qa.push_back(exp[k]);
                done = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL a_accept timeout at %0t: got no D_READY, expected acceptance of %h", $time, d);
            $fatal(1, "handshake timeout");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [WB-1:0] d, input logic [WB-1:0] exp);
        bit done = 1'b0;
        b_d = d;
        b_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #2;
            if (b_ready === 1'b1 && en && !rst) begin
                for (int k = int'(WB) - 1; k >= 0; k--) qb.push_back(exp[k]);
                done = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL b_accept timeout at %0t: got no D_READY, expected acceptance of %h", $time, d);
            $fatal(1, "handshake timeout");
        end
        @(posedge clk); #1;
    endtask

    // Wait for both serializers to go quiet
    task automatic drain(input int cycles);
        bit ok = 1'b0;
        for (int i = 0; i < cycles && !ok; i++) begin
            @(posedge clk); #1;
            if (qa.size() == 0 && qb.size() == 0 && a_oe === 1'b0 && b_oe === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL drain timeout at %0t: got OE=%b/%b, expected both idle", $time, a_oe, b_oe);
            $fatal(1, "drain timeout");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Single word, back-to-back pair, three-word backpressure, then singles
        va[0] = '{8'hA5, 8'b10100101, 1'b0};
        va[1] = '{8'h0F, 8'b11110000, 1'b1};
        va[2] = '{8'hF0, 8'b00001111, 1'b0};
        va[3] = '{8'h01, 8'b10000000, 1'b1};
        va[4] = '{8'h80, 8'b00000001, 1'b1};
        va[5] = '{8'hC3, 8'b11000011, 1'b0};
        va[6] = '{8'h96, 8'b01101001, 1'b0};
        va[7] = '{8'h3C, 8'b00111100, 1'b0};
        vb[0] = '{4'b1000, 4'b1000};
        vb[1] = '{4'b0011, 4'b0011};
        vb[2] = '{4'b0110, 4'b0110};

        rst = 1'b1; en = 1'b1;
        a_d = '0; a_valid = 1'b0;
        b_d = '0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            send_a(va[i].d, va[i].exp);
            if (!va[i].b2b) begin
                a_valid = 1'b0;
                drain(60);
            end
        end

        // MSB-first, idle-low: isolated words, then a streamed pair
        for (int i = 0; i < 3; i++) begin
            send_b(vb[i].d, vb[i].exp);
            b_valid = 1'b0;
            drain(20);
        end
        send_b(4'b1001, 4'b1001);
        send_b(4'b0101, 4'b0101);
        b_valid = 1'b0;
        drain(20);

        // EN freeze for 5 edges once bit 3 of 0x3C is on Q
        send_a(8'h3C, 8'b00111100);
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        drain(40);

        // Reset after bit 2 with a second word parked in the holding register
        send_a(8'hC3, 8'b11000011);
        send_a(8'h5A, 8'b01011010);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(20);

        // Reset while EN is low still takes effect
        send_b(4'b1111, 4'b1111);
        b_valid = 1'b0;
        en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;
        drain(20);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got no completion, expected end of test", $time);
        $fatal(1, "watchdog");
    end

endmodule
